// File: rtl/reset_pkg.sv
// Shared state type and constants for the reset sequencer.
package reset_pkg;

    localparam int STATE_W = 3;

    localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFF0;

    typedef enum logic [STATE_W-1:0] {
        S_RESET,
        S_HOLD,
        S_LOAD,
        S_PREFETCH,
        S_RUN,
        S_FAULT
    } state_t;

endpackage

// File: rtl/reset_hold_deglitch.sv
// Two-flop deglitcher for nrsthold: hold_rel rises only after two
// consecutive high samples, so a single-cycle high pulse never releases.
module reset_hold_deglitch (
    input  logic clk1,
    input  logic reset,
    input  logic nrsthold,
    output logic hold_rel
);

    logic sampleNew;
    logic sampleOld;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            sampleNew <= 1'b0;
            sampleOld <= 1'b0;
        end else begin
            sampleNew <= nrsthold;
            sampleOld <= sampleNew;
        end
    end

    assign hold_rel = sampleNew & sampleOld;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: captures the reset vector while nrsthold is low, then
// loads the PC, launches the first fetch and releases the IR reset.
// Optional hold timeout fault is enabled by defining RESET_TIMEOUT_EN.
module reset_sequencer #(
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        nrsthold,
    input  logic [15:0] ibus,
    output logic [15:0] vector,
    output logic        pc_we,
    output logic        ir_rst,
    output logic        go_fetch,
    output logic        hold_fault
);

    import reset_pkg::*;

    state_t state;
    state_t nextState;
    logic   seen_low;
    logic   hold_rel;

    reset_hold_deglitch uDeglitch (
        .clk1     (clk1),
        .reset    (reset),
        .nrsthold (nrsthold),
        .hold_rel (hold_rel)
    );

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= nextState;
        end
    end

`ifdef RESET_TIMEOUT_EN
    logic [15:0] holdCount;
    logic        holdExpired;

    // Counter sits at zero outside S_HOLD, so every entry starts a fresh count.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            holdCount <= '0;
        end else if (state != S_HOLD) begin
            holdCount <= '0;
        end else begin
            holdCount <= holdCount + 16'd1;
        end
    end

    assign holdExpired = (holdCount == 16'(HOLD_TIMEOUT - 1));
`endif

    // A low sample in S_RUN re-enters S_HOLD and is itself the first capture.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            vector   <= 16'h0000;
            seen_low <= 1'b0;
        end else if ((state == S_HOLD || state == S_RUN) && !nrsthold) begin
            vector   <= ibus;
            seen_low <= 1'b1;
        end else if (state == S_LOAD) begin
            seen_low <= 1'b0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_RESET:    nextState = S_HOLD;
            S_HOLD: begin
                if (seen_low && hold_rel) begin
                    nextState = S_LOAD;
                end
`ifdef RESET_TIMEOUT_EN
                else if (holdExpired) begin
                    nextState = S_FAULT;
                end
`endif
            end
            S_LOAD:     nextState = S_PREFETCH;
            S_PREFETCH: nextState = S_RUN;
            S_RUN: begin
                if (!nrsthold) begin
                    nextState = S_HOLD;
                end
            end
            S_FAULT:    nextState = S_FAULT;
            default:    nextState = S_RESET;
        endcase
    end

    // Outputs decode straight from state, so an async reset kills pulses at once.
    always_comb begin
        pc_we      = 1'b0;
        go_fetch   = 1'b0;
        ir_rst     = 1'b1;
        hold_fault = 1'b0;
        case (state)
            S_LOAD:     pc_we    = 1'b1;
            S_PREFETCH: go_fetch = 1'b1;
            S_RUN:      ir_rst   = 1'b0;
`ifdef RESET_TIMEOUT_EN
            S_FAULT:    hold_fault = 1'b1;
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized
// hold/run traffic, checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_reset_sequencer;

    import reset_pkg::*;

    localparam int HT = 32;
`ifdef RESET_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic        nrsthold = 1'b1;
    logic [15:0] ibus = 16'h0000;
    logic [15:0] vector;
    logic        pc_we;
    logic        ir_rst;
    logic        go_fetch;
    logic        hold_fault;

    int compared = 0;
    int mismatched = 0;
    int pcSeen = 0;
    int goSeen = 0;

    reset_sequencer #(.HOLD_TIMEOUT(HT)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .nrsthold   (nrsthold),
        .ibus       (ibus),
        .vector     (vector),
        .pc_we      (pc_we),
        .ir_rst     (ir_rst),
        .go_fetch   (go_fetch),
        .hold_fault (hold_fault)
    );

    always #5 clk1 = ~clk1;

    // Model: waiting-for-vector flag, age since release, sample history.
    bit          mStarted;
    bit          mInHold;
    bit          mGotLow;
    bit          mFaulted;
    int          mRelAge;
    int          mHoldEdges;
    logic [15:0] mVector;
    bit          mPrev1;
    bit          mPrev2;

    task automatic modelReset();
        mStarted   = 1'b0;
        mInHold    = 1'b0;
        mGotLow    = 1'b0;
        mFaulted   = 1'b0;
        mRelAge    = 0;
        mHoldEdges = 0;
        mVector    = 16'h0000;
        mPrev1     = 1'b0;
        mPrev2     = 1'b0;
    endtask

    task automatic modelEdge(input bit n, input logic [15:0] b);
        bit released;
        bit hadLow;
        released = mPrev1 && mPrev2;
        hadLow   = mGotLow;
        if (!mStarted) begin
            mStarted   = 1'b1;
            mInHold    = 1'b1;
            mHoldEdges = 0;
        end else if (mFaulted) begin
        end else if (mInHold) begin
            if (!n) begin
                mVector = b;
                mGotLow = 1'b1;
            end
            if (hadLow && released) begin
                mInHold = 1'b0;
                mRelAge = 1;
            end else if (TIMEOUT_ON && mHoldEdges == HT - 1) begin
                mFaulted = 1'b1;
            end else begin
                mHoldEdges++;
            end
        end else if (mRelAge >= 3) begin
            if (!n) begin
                mInHold    = 1'b1;
                mHoldEdges = 0;
                mVector    = b;
                mGotLow    = 1'b1;
            end
        end else begin
            if (mRelAge == 1) mGotLow = 1'b0;
            mRelAge++;
        end
        mPrev2 = mPrev1;
        mPrev1 = n;
    endtask

    function automatic bit expPcWe();
        return mStarted && !mInHold && !mFaulted && mRelAge == 1;
    endfunction

    function automatic bit expGoFetch();
        return mStarted && !mInHold && !mFaulted && mRelAge == 2;
    endfunction

    function automatic bit expIrRst();
        return !(mStarted && !mInHold && !mFaulted && mRelAge >= 3);
    endfunction

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".vector"}, vector, mVector);
        checkValue({tag, ".pc_we"}, 16'(pc_we), 16'(expPcWe()));
        checkValue({tag, ".go_fetch"}, 16'(go_fetch), 16'(expGoFetch()));
        checkValue({tag, ".ir_rst"}, 16'(ir_rst), 16'(expIrRst()));
        checkValue({tag, ".hold_fault"}, 16'(hold_fault), 16'(mFaulted));
        checkValue({tag, ".exclusive"}, 16'(pc_we & go_fetch), 16'h0000);
    endtask

    // Drive away from the edge, advance one clock, then check 1ns later.
    task automatic applyStimulus(input bit n, input logic [15:0] b, input string tag);
        nrsthold = n;
        ibus     = b;
        @(posedge clk1);
        if (reset) modelReset();
        else modelEdge(n, b);
        #1;
        if (pc_we === 1'b1) pcSeen++;
        if (go_fetch === 1'b1) goSeen++;
        checkOutput(tag);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases on negedge.
    task automatic doReset(input string tag);
        #2 reset = 1'b1;
        #1 modelReset();
        checkOutput({tag, ".async"});
        @(posedge clk1);
        #1 checkOutput({tag, ".held"});
        @(negedge clk1);
        reset = 1'b0;
    endtask

    initial begin
        int lowLen;
        int hiLen;
        int glitchAt;
        bit reached;

        modelReset();
        #1 reset = 1'b1;
        #1 checkOutput("reset_init");
        repeat (2) @(posedge clk1);
        #1 checkOutput("reset_held");
        @(negedge clk1);
        reset = 1'b0;

        // Power-up: 16 low cycles carrying the default vector, then release.
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, RESET_VECTOR_DEFAULT, "pwr_low");
        applyStimulus(1'b1, 16'($urandom), "pwr_rise_e");
        checkValue("pwr_e.pc_we", 16'(pc_we), 16'h0000);
        applyStimulus(1'b1, 16'($urandom), "pwr_e1");
        checkValue("pwr_e1.pc_we", 16'(pc_we), 16'h0000);
        applyStimulus(1'b1, 16'($urandom), "pwr_e2");
        checkValue("pwr_e2.pc_we", 16'(pc_we), 16'h0001);
        checkValue("pwr_e2.vector", vector, 16'hFFF0);
        applyStimulus(1'b1, 16'($urandom), "pwr_e3");
        checkValue("pwr_e3.go_fetch", 16'(go_fetch), 16'h0001);
        applyStimulus(1'b1, 16'($urandom), "pwr_e4");
        checkValue("pwr_e4.ir_rst", 16'(ir_rst), 16'h0000);
        applyStimulus(1'b1, 16'($urandom), "pwr_run");

        // Re-entry from run: 8 low cycles with ABCD.
        pcSeen = 0;
        goSeen = 0;
        applyStimulus(1'b0, 16'hABCD, "reent_first");
        checkValue("reent_first.ir_rst", 16'(ir_rst), 16'h0001);
        for (int k = 1; k < 8; k++) applyStimulus(1'b0, 16'hABCD, "reent_low");
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 16'($urandom), "reent_high");
        checkValue("reent.pc_count", 16'(pcSeen), 16'h0001);
        checkValue("reent.go_count", 16'(goSeen), 16'h0001);
        checkValue("reent.vector", vector, 16'hABCD);
        checkValue("reent.ir_rst", 16'(ir_rst), 16'h0000);

        // One-cycle high glitch inside hold must not release.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h5555, "glitch_pre");
        pcSeen = 0;
        applyStimulus(1'b1, 16'h9999, "glitch_high");
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h1234, "glitch_post");
        checkValue("glitch.pc_count", 16'(pcSeen), 16'h0000);
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 16'($urandom), "glitch_rel");
        checkValue("glitch.vector", vector, 16'h1234);
        checkValue("glitch.pc_count_final", 16'(pcSeen), 16'h0001);

        // Reset during the load cycle.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h2222, "abort_load_low");
        reached = 1'b0;
        for (int k = 0; k < 8 && !reached; k++) begin
            applyStimulus(1'b1, 16'($urandom), "abort_load_wait");
            reached = (pc_we === 1'b1);
        end
        checkValue("abort_load.reached", 16'(reached), 16'h0001);
        doReset("abort_load");
        checkValue("abort_load.pc_we", 16'(pc_we), 16'h0000);
        checkValue("abort_load.vector", vector, 16'h0000);
        goSeen = 0;
        pcSeen = 0;
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 16'($urandom), "abort_load_after");
        checkValue("abort_load.no_go", 16'(goSeen), 16'h0000);
        checkValue("abort_load.no_pc", 16'(pcSeen), 16'h0000);

        // Reset during the prefetch cycle.
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h3333, "abort_pf_low");
        reached = 1'b0;
        for (int k = 0; k < 8 && !reached; k++) begin
            applyStimulus(1'b1, 16'($urandom), "abort_pf_wait");
            reached = (go_fetch === 1'b1);
        end
        checkValue("abort_pf.reached", 16'(reached), 16'h0001);
        doReset("abort_pf");
        checkValue("abort_pf.go_fetch", 16'(go_fetch), 16'h0000);

        // Long hold: faults only when the timeout is built in.
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 16'($urandom), "long_hold");
        checkValue("long_hold.fault", 16'(hold_fault), 16'(TIMEOUT_ON));
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 16'($urandom), "long_rel");
        checkValue("long_rel.fault", 16'(hold_fault), 16'(TIMEOUT_ON));
        checkValue("long_rel.ir_rst", 16'(ir_rst), 16'(TIMEOUT_ON));
        doReset("fault_clear");
        checkValue("fault_clear.fault", 16'(hold_fault), 16'h0000);

        // Randomized hold/run traffic with occasional glitches and a reset.
        for (int it = 0; it < 12; it++) begin
            lowLen   = $urandom_range(2, 12);
            glitchAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lowLen - 1) : 0;
            for (int k = 0; k < lowLen; k++) begin
                if (glitchAt != 0 && k == glitchAt) applyStimulus(1'b1, 16'($urandom), "rand_glitch");
                applyStimulus(1'b0, 16'($urandom), "rand_low");
            end
            hiLen = $urandom_range(5, 9);
            for (int k = 0; k < hiLen; k++) applyStimulus(1'b1, 16'($urandom), "rand_high");
            if (it == 5) doReset("rand_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_TIMEOUT, default 1024, is the number of clk1 cycles allowed in S_HOLD before a fault is raised (RESET_TIMEOUT_EN only).
REQ-002 Port clk1, input, 1: the one clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port nrsthold, input, 1: active-low reset-hold from the reset timer; ibus carries the reset vector while it is low.
REQ-005 Port ibus, input, 16: internal bus, sampled only for vector capture.
REQ-006 Port vector, output, 16: captured reset vector presented to the PC.
REQ-007 Port pc_we, output, 1: one-cycle PC write strobe for vector.
REQ-008 Port ir_rst, output, 1: active-high IR reset, which forces no-op decode.
REQ-009 Port go_fetch, output, 1: one-cycle pulse starting the first fetch.
REQ-010 Port hold_fault, output, 1: sticky fault flag, cleared only by reset.

Function
REQ-011 The FSM SHALL have exactly these states: S_RESET, S_HOLD, S_LOAD, S_PREFETCH, S_RUN, S_FAULT.
REQ-012 S_RESET SHALL advance to S_HOLD on the first clk1 edge after reset deasserts.
REQ-013 In S_HOLD, every edge with nrsthold=0 SHALL load vector<=ibus and set the internal flag seen_low; the last low-cycle value wins.
REQ-014 The deglitched release hold_rel SHALL be 1 only when nrsthold was sampled 1 on two consecutive edges.
REQ-015 S_HOLD SHALL go to S_LOAD on the edge where seen_low=1 and hold_rel=1; if seen_low=0, hold_rel SHALL be ignored.
REQ-016 S_LOAD SHALL last one cycle with pc_we=1, then go to S_PREFETCH.
REQ-017 S_PREFETCH SHALL last one cycle with go_fetch=1 and ir_rst=1, then go to S_RUN.
REQ-018 S_RUN SHALL drive ir_rst=0, go_fetch=0, pc_we=0.
REQ-019 In S_RUN, nrsthold sampled 0 SHALL re-enter S_HOLD on that edge, clearing seen_low first and then capturing as in REQ-013.
REQ-020 ir_rst SHALL be 1 in every state except S_RUN.
REQ-021 pc_we and go_fetch SHALL never be 1 in the same cycle.
REQ-022 Latency SHALL be exactly: nrsthold rises before edge E; hold_rel=1 after edge E+1; S_LOAD from edge E+2; S_PREFETCH from E+3; S_RUN from E+4.
REQ-023 A nrsthold high pulse of one cycle in S_HOLD SHALL not release; capture SHALL resume.
REQ-024 S_FAULT SHALL hold ir_rst=1, hold_fault=1, and pc_we=go_fetch=0 until reset.

Reset
REQ-025 reset=1 SHALL immediately force: state S_RESET, vector=16'h0000, pc_we=0, go_fetch=0, ir_rst=1, hold_fault=0, seen_low=0, timeout counter=0, deglitch flops=0.
REQ-026 reset asserted in any state, including mid-S_LOAD or mid-S_PREFETCH, SHALL abort with no further pc_we or go_fetch pulse.

Configuration
REQ-027 With RESET_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to S_HOLD and increment on each edge in S_HOLD.
REQ-028 With RESET_TIMEOUT_EN defined, reaching HOLD_TIMEOUT-1 while still in S_HOLD SHALL go to S_FAULT on the next edge; release on the same edge takes priority.
REQ-029 Without RESET_TIMEOUT_EN, S_HOLD SHALL wait indefinitely, hold_fault SHALL be constant 0, S_FAULT SHALL be unreachable and no counter logic SHALL be synthesised.

Structure
REQ-030 Package reset_pkg SHALL hold the state enum, the state encoding width and the constant RESET_VECTOR_DEFAULT=16'hFFF0.
REQ-031 Sub-module reset_hold_deglitch SHALL implement REQ-014: two flops, asynchronous clear, output hold_rel.

Verification
REQ-032 reset pulse, nrsthold low for 16 cycles with ibus=16'hFFF0, then high -> vector=16'hFFF0; pc_we exactly 2 cycles after the rise edge; go_fetch the next cycle; ir_rst=0 from the following cycle.
REQ-033 nrsthold low, one-cycle high glitch, low 4 more cycles with ibus=16'h1234, then high -> no pc_we during the glitch; final vector=16'h1234.
REQ-034 In S_RUN, drive nrsthold low 8 cycles with ibus=16'hABCD -> ir_rst=1 on the first low edge; re-load with vector=16'hABCD; single pc_we, single go_fetch.
REQ-035 reset asserted during the S_LOAD cycle -> pc_we drops immediately; no go_fetch; outputs equal REQ-025 values.
REQ-036 RESET_TIMEOUT_EN, HOLD_TIMEOUT=32, nrsthold held low -> hold_fault=1 at cycle 32 of S_HOLD; later release ignored; only reset clears it.
